// File: rtl/reg_file.sv
// Architectural register file with rename tags (busy bit + RoB producer tag per register).
// Latency: operand reads are combinational (zero cycles); issue/commit/clear take effect at the next edge.
// Backpressure: none internal; rdy low freezes all state while reads keep reflecting the held state.
module reg_file #(
  parameter int ROB_SIZE_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rdy,
  input  logic                      clear,
  input  logic [ROB_SIZE_WIDTH-1:0] issue_rob_id,
  input  logic [4:0]                issue_rd,
  input  logic [ROB_SIZE_WIDTH-1:0] commit_rob_id,
  input  logic [4:0]                commit_rd,
  input  logic [31:0]               commit_value,
  input  logic [4:0]                rs1,
  input  logic [4:0]                rs2,
  output logic [31:0]               val1,
  output logic [31:0]               val2,
  output logic                      has_dep1,
  output logic                      has_dep2,
  output logic [ROB_SIZE_WIDTH-1:0] dep1,
  output logic [ROB_SIZE_WIDTH-1:0] dep2,
  output logic [ROB_SIZE_WIDTH-1:0] get_rob_id1,
  output logic [ROB_SIZE_WIDTH-1:0] get_rob_id2,
  input  logic [31:0]               get_value1,
  input  logic [31:0]               get_value2,
  input  logic                      get_ready1,
  input  logic                      get_ready2
);

  localparam int TW = ROB_SIZE_WIDTH;

  logic [31:0]   regs [32];
  logic [31:0]   busy;
  logic [TW-1:0] tags [32];

  // Architectural values: a commit writes on any enabled edge, flush or not; x0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (rdy && commit_rd != 5'd0) begin
      regs[commit_rd] <= commit_value;
    end
  end

  // Rename state: flush wipes everything; otherwise a matching commit retires, and a
  // same-register issue is evaluated last so the newer producer wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      for (int i = 0; i < 32; i++) tags[i] <= '0;
    end else if (rdy) begin
      if (clear) begin
        busy <= '0;
        for (int i = 0; i < 32; i++) tags[i] <= '0;
      end else begin
        if (commit_rd != 5'd0 && tags[commit_rd] == commit_rob_id) begin
          busy[commit_rd] <= 1'b0;
        end
        if (issue_rd != 5'd0) begin
          busy[issue_rd] <= 1'b1;
          tags[issue_rd] <= issue_rob_id;
        end
      end
    end
  end

  logic [4:0]  rs_a [2];
  logic [31:0] gv_a [2];
  logic        gr_a [2];

  assign rs_a[0] = rs1;
  assign rs_a[1] = rs2;
  assign gv_a[0] = get_value1;
  assign gv_a[1] = get_value2;
  assign gr_a[0] = get_ready1;
  assign gr_a[1] = get_ready2;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [TW-1:0] tag_q;
    logic          busy_q;
    logic          commit_hit;
    logic [31:0]   val;
    logic          has_dep;
    logic [TW-1:0] dep;

    assign tag_q      = tags[rs_a[p]];
    assign busy_q     = busy[rs_a[p]];
    assign commit_hit = rdy && (commit_rd == rs_a[p]) && (commit_rob_id == tag_q);

    // Operand select: x0, then in-flight commit bypass, then RoB lookup, then pending, then file.
    always_comb begin
      val     = '0;
      has_dep = 1'b0;
      dep     = '0;
      if (rs_a[p] == 5'd0) begin
        val = '0;
      end else if (busy_q && commit_hit) begin
        val = commit_value;
      end else if (busy_q && gr_a[p]) begin
        val = gv_a[p];
      end else if (busy_q) begin
        has_dep = 1'b1;
        dep     = tag_q;
      end else begin
        val = regs[rs_a[p]];
      end
    end
  end

  assign val1        = g_rd[0].val;
  assign has_dep1    = g_rd[0].has_dep;
  assign dep1        = g_rd[0].dep;
  assign get_rob_id1 = g_rd[0].tag_q;
  assign val2        = g_rd[1].val;
  assign has_dep2    = g_rd[1].has_dep;
  assign dep2        = g_rd[1].dep;
  assign get_rob_id2 = g_rd[1].tag_q;

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: directed scenarios with literal expectations plus a per-cycle model compare.
// Latency: reads checked combinationally within the cycle; state effects checked after the next edge.
// Backpressure: rdy toggled to confirm the freeze behaviour.
module tb_reg_file;

  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          rdy, clear;
  logic [TW-1:0] issue_rob_id, commit_rob_id;
  logic [4:0]    issue_rd, commit_rd, rs1, rs2;
  logic [31:0]   commit_value, get_value1, get_value2;
  logic          get_ready1, get_ready2;
  logic [31:0]   val1, val2;
  logic          has_dep1, has_dep2;
  logic [TW-1:0] dep1, dep2, get_rob_id1, get_rob_id2;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  reg_file #(.ROB_SIZE_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear(clear),
    .issue_rob_id(issue_rob_id), .issue_rd(issue_rd),
    .commit_rob_id(commit_rob_id), .commit_rd(commit_rd), .commit_value(commit_value),
    .rs1(rs1), .rs2(rs2),
    .val1(val1), .val2(val2), .has_dep1(has_dep1), .has_dep2(has_dep2),
    .dep1(dep1), .dep2(dep2), .get_rob_id1(get_rob_id1), .get_rob_id2(get_rob_id2),
    .get_value1(get_value1), .get_value2(get_value2),
    .get_ready1(get_ready1), .get_ready2(get_ready2)
  );

  initial forever #5 clk = ~clk;

  // Reference state: what each register holds and which producer (if any) it waits on.
  logic [31:0]   m_val  [32];
  logic          m_pend [32];
  logic [TW-1:0] m_prod [32];

  // Apply the architectural rules to the reference state at each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i]  <= '0;
        m_pend[i] <= 1'b0;
        m_prod[i] <= '0;
      end
    end else if (rdy) begin
      if (commit_rd != 0) m_val[commit_rd] <= commit_value;
      if (clear) begin
        for (int i = 0; i < 32; i++) begin
          m_pend[i] <= 1'b0;
          m_prod[i] <= '0;
        end
      end else begin
        if (issue_rd != 0) begin
          m_pend[issue_rd] <= 1'b1;
          m_prod[issue_rd] <= issue_rob_id;
        end
        if (commit_rd != 0 && commit_rd != issue_rd && m_prod[commit_rd] == commit_rob_id)
          m_pend[commit_rd] <= 1'b0;
      end
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_read(input logic [4:0] rs, input logic [31:0] gv, input logic gr,
                            output logic [31:0] v, output logic hd, output logic [TW-1:0] d,
                            output logic [TW-1:0] gid);
    gid = m_prod[rs];
    v = '0; hd = 1'b0; d = '0;
    if (rs == 0) v = '0;
    else if (!m_pend[rs]) v = m_val[rs];
    else if (rdy && commit_rd == rs && commit_rob_id == m_prod[rs]) v = commit_value;
    else if (gr) v = gv;
    else begin hd = 1'b1; d = m_prod[rs]; end
  endtask

  // Compare both read ports against the reference state every cycle away from the edge.
  always @(negedge clk) begin
    logic [31:0] ev; logic eh; logic [TW-1:0] ed, eg;
    if (chk_en && rst_n) begin
      model_read(rs1, get_value1, get_ready1, ev, eh, ed, eg);
      cmp("p1_val", val1, ev); cmp("p1_hasdep", 32'(has_dep1), 32'(eh));
      cmp("p1_dep", 32'(dep1), 32'(ed)); cmp("p1_robid", 32'(get_rob_id1), 32'(eg));
      model_read(rs2, get_value2, get_ready2, ev, eh, ed, eg);
      cmp("p2_val", val2, ev); cmp("p2_hasdep", 32'(has_dep2), 32'(eh));
      cmp("p2_dep", 32'(dep2), 32'(ed)); cmp("p2_robid", 32'(get_rob_id2), 32'(eg));
    end
  end

  task automatic idle();
    rdy = 1'b1; clear = 1'b0;
    issue_rd = 0; issue_rob_id = 0;
    commit_rd = 0; commit_rob_id = 0; commit_value = 0;
    get_ready1 = 0; get_ready2 = 0; get_value1 = 0; get_value2 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rs1 = 5; rs2 = 7;
    #1 rst_n = 1'b0;
    #2;
    cmp("reset_val1", val1, 32'h0);
    cmp("reset_hasdep1", 32'(has_dep1), 0);
    cmp("reset_dep1", 32'(dep1), 0);
    cmp("reset_robid2", 32'(get_rob_id2), 0);
    #9 rst_n = 1'b1;
    chk_en = 1'b1;
    tick();

    // Issue x5 <- tag 3, then read it as pending.
    issue_rd = 5; issue_rob_id = 3;
    tick();
    idle(); rs1 = 5;
    #1;
    cmp("pend_hasdep1", 32'(has_dep1), 1);
    cmp("pend_dep1", 32'(dep1), 3);
    cmp("pend_robid1", 32'(get_rob_id1), 3);
    get_ready1 = 1; get_value1 = 32'h1234;
    #1;
    cmp("robhit_val1", val1, 32'h1234);
    cmp("robhit_hasdep1", 32'(has_dep1), 0);
    cmp("robhit_dep1", 32'(dep1), 0);
    commit_rd = 5; commit_rob_id = 3; commit_value = 32'hABCD;
    #1;
    cmp("bypass_val1", val1, 32'hABCD);
    tick();
    idle();
    #1;
    cmp("retired_val1", val1, 32'hABCD);
    cmp("retired_hasdep1", 32'(has_dep1), 0);

    // Two producers for x7; retiring the older one leaves the younger pending.
    issue_rd = 7; issue_rob_id = 1;
    tick();
    issue_rd = 7; issue_rob_id = 2;
    tick();
    idle(); commit_rd = 7; commit_rob_id = 1; commit_value = 9;
    tick();
    idle(); rs1 = 7;
    #1;
    cmp("young_hasdep1", 32'(has_dep1), 1);
    cmp("young_dep1", 32'(dep1), 2);

    // Same-cycle issue and commit on x4: issue wins, value still lands.
    issue_rd = 4; issue_rob_id = 5;
    tick();
    issue_rd = 4; issue_rob_id = 6; commit_rd = 4; commit_rob_id = 5; commit_value = 32'h55;
    rs2 = 4;
    #1;
    cmp("samecyc_bypass_val2", val2, 32'h55);
    tick();
    idle();
    #1;
    cmp("samecyc_hasdep2", 32'(has_dep2), 1);
    cmp("samecyc_dep2", 32'(dep2), 6);
    cmp("samecyc_robid2", 32'(get_rob_id2), 6);

    // Flush with three busy registers, a dropped issue and a surviving commit write.
    issue_rd = 9; issue_rob_id = 7;
    tick();
    idle(); clear = 1; issue_rd = 8; issue_rob_id = 1;
    commit_rd = 10; commit_value = 32'hA0;
    tick();
    idle(); rs1 = 7; rs2 = 4;
    #1;
    cmp("flush_val1_x7", val1, 32'h9);
    cmp("flush_hasdep1", 32'(has_dep1), 0);
    cmp("flush_val2_x4", val2, 32'h55);
    cmp("flush_dep2", 32'(dep2), 0);
    rs1 = 8; rs2 = 9;
    #1;
    cmp("flush_x8_hasdep", 32'(has_dep1), 0);
    cmp("flush_x8_robid", 32'(get_rob_id1), 0);
    cmp("flush_x9_hasdep", 32'(has_dep2), 0);
    rs1 = 10;
    #1;
    cmp("flush_commit_x10", val1, 32'hA0);
    issue_rd = 0; issue_rob_id = 3; commit_rd = 0; commit_value = 32'hFF;
    tick();
    idle(); rs1 = 0;
    #1;
    cmp("x0_val1", val1, 0);
    cmp("x0_hasdep1", 32'(has_dep1), 0);

    // Freeze: nothing changes while rdy is low.
    commit_rd = 3; commit_value = 32'h33;
    tick();
    idle(); rdy = 0; issue_rd = 3; issue_rob_id = 4; commit_rd = 3; commit_value = 32'h44;
    tick();
    tick();
    rs1 = 3;
    #1;
    cmp("frozen_val1", val1, 32'h33);
    cmp("frozen_hasdep1", 32'(has_dep1), 0);
    idle();

    // Mid-run reset clears everything; next edge accepts work immediately.
    issue_rd = 11; issue_rob_id = 5;
    tick();
    idle(); rs1 = 11; rs2 = 3;
    #1 rst_n = 1'b0;
    #1;
    cmp("midrst_hasdep1", 32'(has_dep1), 0);
    cmp("midrst_dep1", 32'(dep1), 0);
    cmp("midrst_robid1", 32'(get_rob_id1), 0);
    cmp("midrst_val2", val2, 0);
    #1 rst_n = 1'b1;
    issue_rd = 12; issue_rob_id = 9;
    tick();
    idle(); rs1 = 12;
    #1;
    cmp("postrst_hasdep1", 32'(has_dep1), 1);
    cmp("postrst_dep1", 32'(dep1), 9);

    // Mixed traffic checked by the per-cycle comparator.
    for (int n = 0; n < 400; n++) begin
      idle();
      rdy          = ($urandom_range(0, 7) != 0);
      clear        = ($urandom_range(0, 15) == 0);
      issue_rd     = 5'($urandom_range(0, 31));
      issue_rob_id = TW'($urandom);
      commit_rd    = 5'($urandom_range(0, 31));
      commit_rob_id = ($urandom_range(0, 2) != 0) ? m_prod[commit_rd] : TW'($urandom);
      commit_value = $urandom;
      rs1          = ($urandom_range(0, 3) == 0) ? commit_rd : 5'($urandom_range(0, 31));
      rs2          = ($urandom_range(0, 3) == 0) ? issue_rd : 5'($urandom_range(0, 31));
      get_ready1   = $urandom_range(0, 1) != 0;
      get_ready2   = $urandom_range(0, 1) != 0;
      get_value1   = $urandom;
      get_value2   = $urandom;
      tick();
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
